uart_receive: RTL

- Serial-to-parallel UART receiver. It is the receive end of the team's one-wire UART link, paired with the existing UART transmitter.
- Frame format: idle high, one start bit (0), D_WIDTH data bits LSB first, one stop bit (1).
- Each data word is delivered to the consumer on a valid/ack handshake, with frame-error and overrun reporting.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_receive_if.sv | 34 +++
 rtl/uart_rx_sync.sv | 37 +++
 rtl/uart_receive.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings,
// serial framing bit values and the default data width.
package uart_pkg;

    localparam int unsigned UART_D_WIDTH = 8;

    // Serial framing levels
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Receiver state encodings
    localparam int unsigned ST_W = 3;
    typedef logic [ST_W-1:0] uart_state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_receive_if.sv
// Consumer-side bus of the UART receiver: received word, valid/ack
// handshake, busy status and error pulses.
interface uart_receive_if #(
    parameter int unsigned D_WIDTH = uart_pkg::UART_D_WIDTH
) ();

    logic [D_WIDTH-1:0] rx_data;
    logic               rx_valid;
    logic               rx_ack;
    logic               rx_busy;
    logic               frame_err;
    logic               overrun;

    // Receiver side
    modport master (
        output rx_data,
        output rx_valid,
        output rx_busy,
        output frame_err,
        output overrun,
        input  rx_ack
    );

    // Consumer side
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_busy,
        input  frame_err,
        input  overrun,
        output rx_ack
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial input, resetting to the idle
// (high) line level. Only present in builds with UART_RX_SYNC_EN defined,
// since nothing instantiates it otherwise.
`ifdef UART_RX_SYNC_EN
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic rx_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next-state of the two synchronizer stages
    always_comb begin
        meta_d = rx_in;
        sync_d = meta_q;
    end

    // Synchronizer flops, reset to idle line level
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= STOP_BIT;
            sync_q <= STOP_BIT;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign rx_out = sync_q;

endmodule
`endif

// File: rtl/uart_receive.sv
// UART receiver: idle-high line, one start bit, D_WIDTH data bits LSB
// first, one stop bit. Words are handed over on a valid/ack handshake
// with frame-error and overrun pulses.
// Optional: define UART_RX_SYNC_EN to pass rx through a two-flop
// synchronizer (adds two cycles of latency) for asynchronous sources.
module uart_receive
    import uart_pkg::*;
#(
    parameter int unsigned D_WIDTH      = UART_D_WIDTH,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned CNT_WIDTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    uart_receive_if.master    bus
);

    localparam int unsigned SAMPLE_PT = CLKS_PER_BIT / 2;
    // Counter value to load on the cycle the start edge is seen, so that
    // this cycle counts as the first clock of the start bit.
    localparam int unsigned CNT_START = (CLKS_PER_BIT == 1) ? 0 : 1;

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_rx_sync (
        .clk    (clk),
        .rst    (rst),
        .rx_in  (rx),
        .rx_out (rx_s)
    );
`else
    assign rx_s = rx;
`endif

    uart_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0] samp_cnt_q, samp_cnt_d;
    logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [D_WIDTH-1:0]   shift_q, shift_d;
    logic [D_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_busy_q, rx_busy_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic                 sample_c;
    logic [CNT_WIDTH-1:0] samp_wrap_c;

    // Mid-bit sample strobe and free-running per-bit cycle counter
    always_comb begin
        sample_c    = (samp_cnt_q == CNT_WIDTH'(SAMPLE_PT));
        samp_wrap_c = (samp_cnt_q == CNT_WIDTH'(CLKS_PER_BIT - 1))
                    ? '0 : samp_cnt_q + CNT_WIDTH'(1);
    end

    // Next-state, datapath and flag logic
    always_comb begin
        state_d     = state_q;
        samp_cnt_d  = samp_wrap_c;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~bus.rx_ack;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                samp_cnt_d = '0;
                bit_cnt_d  = '0;
                if (rx_s == START_BIT) begin
                    samp_cnt_d = CNT_WIDTH'(CNT_START);
                    // With one clock per bit the start bit is already at
                    // its sample point, so it is confirmed right here.
                    state_d    = (CLKS_PER_BIT == 1) ? ST_DATA : ST_START;
                end
            end

            ST_START: begin
                if (sample_c) begin
                    if (rx_s == START_BIT) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d    = ST_IDLE;
                        samp_cnt_d = '0;
                    end
                end
            end

            ST_DATA: begin
                if (sample_c) begin
                    shift_d = {rx_s, shift_q[D_WIDTH-1:1]};
                    if (bit_cnt_q == CNT_WIDTH'(D_WIDTH - 1)) begin
                        state_d   = ST_STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end

            ST_STOP: begin
                if (sample_c) begin
                    samp_cnt_d = '0;
                    if (rx_s == STOP_BIT) begin
                        // New word wins over a same-cycle ack
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        overrun_d  = rx_valid_q & ~bus.rx_ack;
                        state_d    = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end

            ST_BREAK: begin
                // Hold off until the line returns high so a stuck-low
                // line cannot start new frames.
                samp_cnt_d = '0;
                if (rx_s == STOP_BIT) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                samp_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase

        rx_busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            samp_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_busy_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_cnt_q  <= samp_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_busy_q   <= rx_busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_busy   = rx_busy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule
